// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a framed program image over a host byte interface,
//            assembles big-endian 32-bit words and writes them to the
//            instruction memory from address 0. Holds the processor in reset
//            until a whole frame with a good checksum has been written.
// Revision : 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 1024,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0]   C_DEPTH32 = DEPTH;
  localparam logic [ADDR_W:0] C_DEPTH = C_DEPTH32[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [1:0]  r_idx;
  logic [23:0] r_word;
  logic [7:0]  r_acc;

  logic        w_xfer;
  logic        w_hdr;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last_word;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_hdr       = w_xfer && (rx_data == HDR);
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > C_DEPTH32);
  assign w_last_word = ((32'(word_count) + 32'd1) == 32'(r_len));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; only WRITE advances without a byte transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_hdr) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (w_xfer && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE:  w_next = w_last_word ? S_CHECK : S_DATA;
      S_CHECK:  if (w_xfer) w_next = (rx_data == r_acc) ? S_DONE : S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; the write strobe and ready are derived
  // from the upcoming state so they line up with the WRITE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_acc      <= '0;
    end else begin
      rx_ready <= (w_next != S_WRITE);
      imem_we  <= (w_next == S_WRITE);
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_hdr) begin
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            r_acc      <= '0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) r_len_hi <= rx_data;
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            r_idx <= 2'd0;
            if (w_len_bad) error <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[15:0], rx_data};
            r_acc  <= r_acc ^ rx_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              imem_addr  <= word_count[ADDR_W-1:0];
              imem_wdata <= {r_word, rx_data};
            end
          end
        end
        S_WRITE: begin
          if (word_count != C_DEPTH) word_count <= word_count + 1'b1;
        end
        S_CHECK: begin
          if (w_xfer) begin
            if (rx_data == r_acc) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              error     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader (frame table + corner
//            sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .HDR(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int low_cnt = 0;

  // Observe memory writes and ready-low cycles
  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_we) begin
        wa.push_back(32'(imem_addr));
        wd.push_back(imem_wdata);
      end
      if (!rx_ready) low_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [127:0] bytes;
    int           n;
    int           gap;
    logic         done_e;
    logic         err_e;
    logic         cpu_e;
    int           wc_e;
    int           nw_e;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t tv[6];

  function automatic vec_t mk(input logic [127:0] b, input int n, input int gap,
                              input logic d, input logic e, input logic c,
                              input int wc, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.bytes = b; v.n = n; v.gap = gap; v.done_e = d; v.err_e = e; v.cpu_e = c;
    v.wc_e = wc; v.nw_e = nw; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int id);
    wa.delete();
    wd.delete();
    low_cnt = 0;
    for (int k = 0; k < v.n; k++) send(v.bytes[(v.n-1-k)*8 +: 8], v.gap);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done", id), 32'(done), 32'(v.done_e));
    chk($sformatf("v%0d_error", id), 32'(error), 32'(v.err_e));
    chk($sformatf("v%0d_cpu_reset", id), 32'(cpu_reset), 32'(v.cpu_e));
    chk($sformatf("v%0d_word_count", id), 32'(word_count), 32'(v.wc_e));
    chk($sformatf("v%0d_nwrites", id), 32'(wa.size()), 32'(v.nw_e));
    chk($sformatf("v%0d_ready_low", id), 32'(low_cnt), 32'(v.nw_e));
    if (wa.size() > 0 && v.nw_e > 0) begin
      chk($sformatf("v%0d_addr0", id), wa[0], 32'd0);
      chk($sformatf("v%0d_data0", id), wd[0], v.w0);
    end
    if (wa.size() > 1 && v.nw_e > 1) begin
      chk($sformatf("v%0d_addr1", id), wa[1], 32'd1);
      chk($sformatf("v%0d_data1", id), wd[1], v.w1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // normal load, continuous valid (backpressure)
    tv[0] = mk({8'hA5,8'h00,8'h02,8'h40,8'h00,8'h00,8'h05,8'h40,8'h00,8'h00,8'h03,8'h06},
               12, 0, 1'b1, 1'b0, 1'b0, 2, 2, 32'h40000005, 32'h40000003);
    // bad checksum
    tv[1] = mk({8'hA5,8'h00,8'h02,8'h40,8'h00,8'h00,8'h05,8'h40,8'h00,8'h00,8'h03,8'h07},
               12, 0, 1'b0, 1'b1, 1'b1, 2, 2, 32'h40000005, 32'h40000003);
    // zero length
    tv[2] = mk({8'hA5,8'h00,8'h00}, 3, 0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0);
    // length 1025
    tv[3] = mk({8'hA5,8'h04,8'h01}, 3, 0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0);
    // recovery with single word
    tv[4] = mk({8'hA5,8'h00,8'h01,8'h11,8'h22,8'h33,8'h44,8'h44},
               8, 1, 1'b1, 1'b0, 1'b0, 1, 1, 32'h11223344, 32'h0);
    // garbage prefix, 3-cycle gaps between bytes
    tv[5] = mk({8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h02,8'h40,8'h00,8'h00,8'h05,
                8'h40,8'h00,8'h00,8'h03,8'h06},
               15, 3, 1'b1, 1'b0, 1'b0, 2, 2, 32'h40000005, 32'h40000003);

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    #1;
    chk("ready_first_cycle", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_first", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 6; i++) apply(tv[i], i);

    // Write timing and reset mid-frame
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h40, 0); send(8'h00, 0); send(8'h00, 0); send(8'h05, 0);
    @(negedge clk);
    chk("mid_we", 32'(imem_we), 32'd1);
    chk("mid_addr", 32'(imem_addr), 32'd0);
    chk("mid_data", imem_wdata, 32'h40000005);
    chk("mid_ready", 32'(rx_ready), 32'd0);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("mid_we_drop", 32'(imem_we), 32'd0);
    chk("mid_wc", 32'(word_count), 32'd1);
    send(8'h40, 0); send(8'h00, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_first_cycle2", 32'(rx_ready), 32'd0);
    @(negedge clk);
    apply(tv[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer for the stack processor's 32-bit instruction memory; the processor only reads that memory.
- Receives a framed program image from a host byte interface, assembles big-endian 32-bit instruction words and writes them to consecutive addresses from 0.
- Holds the processor in reset until a complete frame with a valid checksum has been written.

Parameters:
ADDR_W, 10, instruction memory address width
DEPTH, 1024, maximum words per frame (must be <= 2**ADDR_W)
HDR, 8'hA5, frame start byte

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
rx_valid  input  1  host byte valid
rx_data  input  8  host byte
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready on a rising edge
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  instruction word
cpu_reset  output  1  active-high reset to the processor
done  output  1  last frame loaded successfully
error  output  1  last frame rejected
word_count  output  ADDR_W+1  words written in the current or last frame

Behaviour:
- Reset is asynchronous and active-low; all outputs are registered. Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0, state=IDLE.
- Frame format: HDR, LEN_HI, LEN_LO, N*4 payload bytes (MSB first), CHK. CHK is the XOR of all payload bytes. N = {LEN_HI,LEN_LO}.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
- rx_ready is 1 in every state except WRITE. It is 0 in the first cycle after reset deasserts, then 1.
- IDLE: a byte equal to HDR goes to LEN_HI, sets cpu_reset=1 and clears done, error, word_count and the checksum accumulator. Any other byte is discarded.
- LEN_HI captures the high byte of N. LEN_LO captures the low byte, then:
  - N==0 or N>DEPTH: go to ERROR.
  - otherwise: go to DATA with byte index 0.
- DATA: shift each byte into the word register (MSB first) and XOR it into the accumulator. After the 4th byte, go to WRITE.
- WRITE (exactly one cycle): imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word, rx_ready=0. The write is visible on imem_* one cycle after the 4th byte is accepted. word_count increments at the end of WRITE. Next state is CHECK if word_count+1==N, else DATA.
- imem_we is 0 in all states other than WRITE. imem_addr and imem_wdata hold their last value.
- CHECK: the next accepted byte is compared with the accumulator.
  - Match: go to DONE; done=1 and cpu_reset=0 from the next cycle.
  - Mismatch: go to ERROR; error=1 and cpu_reset stays 1.
- DONE and ERROR: HDR restarts the frame (same actions as in IDLE). Other bytes are discarded and the flags hold.
- rx_valid may drop at any time between bytes. The loader waits with no timeout and keeps its state.
- Asynchronous reset mid-frame: immediate return to reset values and IDLE. Words already written are not erased.
- Words are written to memory before the checksum is verified. A rejected frame leaves partially or wholly written memory, but cpu_reset stays 1.
- word_count saturates at DEPTH. It cannot wrap because N<=DEPTH.

Test Plan:
- Normal load: A5 00 02 40 00 00 05 40 00 00 03 06 -> imem_we pulses with addr 0/data 0x40000005, then addr 1/data 0x40000003; done=1, cpu_reset=0 one cycle after CHK; word_count=2.
- Bad checksum: same frame with CHK=07 -> both words written; error=1, done=0, cpu_reset stays 1.
- Bad length: A5 00 00, and separately A5 04 01 (N=1025) -> ERROR after LEN_LO with no imem_we; then A5 00 01 11 22 33 44 44 -> recovers: addr 0 = 0x11223344, done=1.
- Garbage and gaps: 00 FF 5A before A5, rx_valid held low 3 cycles between every byte -> garbage ignored; result identical to the normal load.
- Backpressure: rx_valid held high continuously -> rx_ready=0 for exactly one cycle after every 4th payload byte; no byte is lost or duplicated; word order is correct.
- Reset mid-frame: reset_n low after 6 payload bytes -> all outputs at reset values; a following full normal load succeeds.
